// File: rtl/inta_seq_pkg.sv
// rtl/inta_seq_pkg.sv - shared state encoding, OCW2 command bytes and counter sizing for inta_sequencer
package inta_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INTA1,
        GAP,
        INTA2,
        SERVICE,
        EOI_WR,
        RECOVER
    } state_t;

    localparam logic [7:0] OCW2_NS_EOI = 8'h20;
    localparam logic [7:0] OCW2_SP_EOI = 8'h60;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/inta_pulse_timer.sv
// rtl/inta_pulse_timer.sv - loadable down-counter; done is high while the count sits at zero
module inta_pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - 8259 INTA acknowledge sequencer with vector capture and EOI write; INTA_SEQ_SPECIFIC_EOI_EN selects specific EOI
module inta_sequencer
    import inta_seq_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2,
    parameter int EOI_WR_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic       int_enable,
    input  logic       auto_eoi,
    input  logic       ack,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
);

    localparam int W = cnt_width(INTA_LOW_CYCLES, INTA_GAP_CYCLES, EOI_WR_CYCLES);
    localparam logic [W-1:0] LOW_LOAD = W'(INTA_LOW_CYCLES - 1);
    localparam logic [W-1:0] GAP_LOAD = W'(INTA_GAP_CYCLES - 1);
    localparam logic [W-1:0] EOI_LOAD = W'(EOI_WR_CYCLES - 1);

    state_t       state, next_state;
    logic         t_load;
    logic [W-1:0] t_load_val;
    logic         t_done;
    logic         capture;
    logic [7:0]   ocw2;

    inta_pulse_timer #(.W(W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_load_val),
        .done     (t_done)
    );

`ifdef INTA_SEQ_SPECIFIC_EOI_EN
    assign ocw2 = OCW2_SP_EOI | {5'b0, vector[2:0]};
`else
    assign ocw2 = OCW2_NS_EOI;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Timer is loaded on entry to each timed phase, so it reads zero on that phase's last cycle.
    always_comb begin
        next_state = state;
        t_load     = 1'b0;
        t_load_val = '0;
        capture    = 1'b0;
        case (state)
            IDLE: if (int_req && int_enable) begin
                next_state = INTA1;
                t_load     = 1'b1;
                t_load_val = LOW_LOAD;
            end
            INTA1: if (t_done) begin
                next_state = GAP;
                t_load     = 1'b1;
                t_load_val = GAP_LOAD;
            end
            GAP: if (t_done) begin
                next_state = INTA2;
                t_load     = 1'b1;
                t_load_val = LOW_LOAD;
            end
            INTA2: if (t_done) begin
                next_state = SERVICE;
                capture    = 1'b1;
            end
            SERVICE: begin
                if (auto_eoi) begin
                    next_state = RECOVER;
                end else if (ack) begin
                    next_state = EOI_WR;
                    t_load     = 1'b1;
                    t_load_val = EOI_LOAD;
                end
            end
            EOI_WR:  if (t_done) next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so each strobe lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inta_n       <= 1'b1;
            wr_n         <= 1'b1;
            data_out     <= 8'h00;
            data_oe      <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            inta_n       <= !(next_state == INTA1 || next_state == INTA2);
            wr_n         <= (next_state != EOI_WR);
            data_oe      <= (next_state == EOI_WR);
            vector_valid <= capture;
            busy         <= (next_state != IDLE);
            if (capture) vector <= data_in;
            if (next_state == EOI_WR && state != EOI_WR) data_out <= ocw2;
        end
    end

    assign a0 = 1'b0;

endmodule
